conv_mac_pipe: RTL and testbench

CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

---
 rtl/conv_mac_pipe_if.sv | 35 +++
 rtl/conv_mac_pipe.sv | 108 ++++++++++
 tb/tb_conv_mac_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_pipe_if.sv
// Operand window, kernel and result bus of the 3x3 MAC pipeline.
// master drives operands and strobes; slave returns results.
interface conv_mac_pipe_if #(
  parameter int SIZE_1 = 11,
  parameter int CNT_W  = 10
);
  logic go;
  logic clr;
  logic signed [SIZE_1-1:0] p1, p2, p3;
  logic signed [SIZE_1-1:0] p4, p5, p6;
  logic signed [SIZE_1-1:0] p7, p8, p9;
  logic signed [SIZE_1-1:0] w11, w12, w13;
  logic signed [SIZE_1-1:0] w14, w15, w16;
  logic signed [SIZE_1-1:0] w17, w18, w19;
  logic signed [2*SIZE_1-2:0] Y1;
  logic valid;
  logic ovf;
  logic [CNT_W-1:0] res_cnt;

  modport master (
    output go, clr,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9,
    output w11, w12, w13, w14, w15, w16,
    output w17, w18, w19,
    input  Y1, valid, ovf, res_cnt
  );

  modport slave (
    input  go, clr,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9,
    input  w11, w12, w13, w14, w15, w16,
    input  w17, w18, w19,
    output Y1, valid, ovf, res_cnt
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// Two-stage 3x3 signed multiply-accumulate: products, then
// saturated sum with sticky overflow and a result counter.
module conv_mac_pipe #(
  parameter int SIZE_1 = 11,
  parameter int CNT_W  = 10
) (
  input logic clk,
  input logic rst_n,
  conv_mac_pipe_if.slave bus
);
  localparam int PW = 2*SIZE_1;
  localparam int SW = PW+4;
  localparam int YW = PW-1;

  typedef logic signed [SIZE_1-1:0] opnd_t;
  typedef logic signed [PW-1:0] prod_t;

  opnd_t p [9];
  opnd_t w [9];
  prod_t prod [9];
  logic v1;

  logic signed [SW-1:0] sum;
  logic hi;
  logic lo;
  logic signed [YW-1:0] sat_val;

  logic signed [YW-1:0] y1;
  logic valid_q;
  logic ovf_q;
  logic [CNT_W-1:0] cnt_q;

  assign p[0] = bus.p1;
  assign p[1] = bus.p2;
  assign p[2] = bus.p3;
  assign p[3] = bus.p4;
  assign p[4] = bus.p5;
  assign p[5] = bus.p6;
  assign p[6] = bus.p7;
  assign p[7] = bus.p8;
  assign p[8] = bus.p9;
  assign w[0] = bus.w11;
  assign w[1] = bus.w12;
  assign w[2] = bus.w13;
  assign w[3] = bus.w14;
  assign w[4] = bus.w15;
  assign w[5] = bus.w16;
  assign w[6] = bus.w17;
  assign w[7] = bus.w18;
  assign w[8] = bus.w19;

  function automatic prod_t sx(input opnd_t a);
    return {{SIZE_1{a[SIZE_1-1]}}, a};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int i = 0; i < 9; i++)
        prod[i] <= '0;
    end else begin
      v1 <= bus.go;
      for (int i = 0; i < 9; i++)
        prod[i] <= sx(p[i]) * sx(w[i]);
    end
  end

  // Four guard bits hold the nine-term sum exactly.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++)
      sum = sum + {{4{prod[i][PW-1]}}, prod[i]};
  end

  assign hi = ~sum[SW-1] & (|sum[SW-2:YW-1]);
  assign lo = sum[SW-1] & ~(&sum[SW-2:YW-1]);

  always_comb begin
    sat_val = sum[YW-1:0];
    unique case (1'b1)
      hi: sat_val = {1'b0, {(YW-1){1'b1}}};
      lo: sat_val = {1'b1, {(YW-1){1'b0}}};
      default: sat_val = sum[YW-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1      <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= v1;
      if (v1)
        y1 <= sat_val;
      // A landing result wins over a simultaneous clear.
      ovf_q <= (ovf_q & ~bus.clr) | (v1 & (hi | lo));
      cnt_q <= (bus.clr ? '0 : cnt_q)
             + {{(CNT_W-1){1'b0}}, v1};
    end
  end

  assign bus.Y1      = y1;
  assign bus.valid   = valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.res_cnt = cnt_q;
endmodule

// File: tb/tb_conv_mac_pipe.sv
// Bench for conv_mac_pipe: directed literal cases plus random
// traffic checked every cycle against a queue-based model.
module tb_conv_mac_pipe;
  localparam int SZ = 11;
  localparam int CW = 10;
  localparam longint LIM = 64'sd1 <<< (2*SZ-2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_mac_pipe_if #(.SIZE_1(SZ), .CNT_W(CW)) bus();

  conv_mac_pipe #(.SIZE_1(SZ), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int pa [9];
  int wa [9];

  typedef struct {
    int     due;
    longint val;
    bit     sat;
  } res_t;

  res_t   pend [$];
  int     cyc = 0;
  bit     m_valid = 1'b0;
  bit     m_ovf = 1'b0;
  longint m_y = 0;
  int     m_cnt = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setall(input int pv, input int wv);
    for (int i = 0; i < 9; i++) begin
      pa[i] = pv;
      wa[i] = wv;
    end
  endtask

  function automatic int rnd_op();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return -1024;
    if (r == 1) return 1023;
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic drive(input bit g, input bit c);
    bus.go  = g;
    bus.clr = c;
    bus.p1 = SZ'(pa[0]); bus.p2 = SZ'(pa[1]);
    bus.p3 = SZ'(pa[2]); bus.p4 = SZ'(pa[3]);
    bus.p5 = SZ'(pa[4]); bus.p6 = SZ'(pa[5]);
    bus.p7 = SZ'(pa[6]); bus.p8 = SZ'(pa[7]);
    bus.p9 = SZ'(pa[8]);
    bus.w11 = SZ'(wa[0]); bus.w12 = SZ'(wa[1]);
    bus.w13 = SZ'(wa[2]); bus.w14 = SZ'(wa[3]);
    bus.w15 = SZ'(wa[4]); bus.w16 = SZ'(wa[5]);
    bus.w17 = SZ'(wa[6]); bus.w18 = SZ'(wa[7]);
    bus.w19 = SZ'(wa[8]);
  endtask

  function automatic longint dotp();
    longint s;
    s = 0;
    s += longint'(bus.p1) * longint'(bus.w11);
    s += longint'(bus.p2) * longint'(bus.w12);
    s += longint'(bus.p3) * longint'(bus.w13);
    s += longint'(bus.p4) * longint'(bus.w14);
    s += longint'(bus.p5) * longint'(bus.w15);
    s += longint'(bus.p6) * longint'(bus.w16);
    s += longint'(bus.p7) * longint'(bus.w17);
    s += longint'(bus.p8) * longint'(bus.w18);
    s += longint'(bus.p9) * longint'(bus.w19);
    return s;
  endfunction

  // Reference: a go sampled at edge K lands at edge K+1.
  always @(posedge clk or negedge rst_n) begin : model
    longint s;
    bit     land;
    res_t   r;
    if (!rst_n) begin
      pend.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_y     = 0;
      m_cnt   = 0;
    end else begin
      cyc++;
      land = 1'b0;
      r = '{due: 0, val: 0, sat: 1'b0};
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        land = 1'b1;
      end
      m_valid = land;
      if (bus.clr) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
      if (land) begin
        m_y   = r.val;
        m_ovf = m_ovf | r.sat;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (bus.go) begin
        s = dotp();
        r.due = cyc + 1;
        r.sat = 1'b0;
        r.val = s;
        if (s > LIM - 1) begin
          r.val = LIM - 1;
          r.sat = 1'b1;
        end else if (s < -LIM) begin
          r.val = -LIM;
          r.sat = 1'b1;
        end
        pend.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_valid", longint'(bus.valid), longint'(m_valid));
    chk("cmp_y1", longint'($signed(bus.Y1)), m_y);
    chk("cmp_ovf", longint'(bus.ovf), longint'(m_ovf));
    chk("cmp_res_cnt", longint'(bus.res_cnt), longint'(m_cnt));
  end

  initial begin
    setall(0, 0);
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", longint'(bus.valid), 0);
    chk("rst_y1", longint'($signed(bus.Y1)), 0);
    chk("rst_ovf", longint'(bus.ovf), 0);
    chk("rst_cnt", longint'(bus.res_cnt), 0);

    setall(1, 1);
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    tick();
    chk("ones_valid", longint'(bus.valid), 1);
    chk("ones_y1", longint'($signed(bus.Y1)), 9);
    chk("ones_cnt", longint'(bus.res_cnt), 1);
    chk("ones_ovf", longint'(bus.ovf), 0);
    tick();
    chk("ones_pulse", longint'(bus.valid), 0);

    for (int i = 0; i < 9; i++) begin
      pa[i] = i + 1;
      wa[i] = 9 - i;
    end
    drive(1'b1, 1'b0);
    tick();
    setall(-7, 300);
    drive(1'b0, 1'b0);
    tick();
    chk("ramp_valid", longint'(bus.valid), 1);
    chk("ramp_y1", longint'($signed(bus.Y1)), 165);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ramp_hold_valid", longint'(bus.valid), 0);
      chk("ramp_hold_y1", longint'($signed(bus.Y1)), 165);
    end

    setall(1023, 1023);
    drive(1'b1, 1'b0);
    tick();
    setall(1023, -1024);
    drive(1'b1, 1'b0);
    tick();
    chk("satpos_y1", longint'($signed(bus.Y1)), 1048575);
    chk("satpos_ovf", longint'(bus.ovf), 1);
    drive(1'b0, 1'b0);
    tick();
    chk("satneg_y1", longint'($signed(bus.Y1)), -1048576);

    setall(2, 3);
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1);
    tick();
    chk("clr_ovf", longint'(bus.ovf), 0);
    chk("clr_cnt", longint'(bus.res_cnt), 1);
    chk("clr_y1", longint'($signed(bus.Y1)), 54);

    setall(1023, 1023);
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1);
    tick();
    chk("clrsat_ovf", longint'(bus.ovf), 1);
    chk("clrsat_cnt", longint'(bus.res_cnt), 1);

    drive(1'b0, 1'b1);
    tick();
    chk("clr_only_cnt", longint'(bus.res_cnt), 0);
    for (int k = 1; k <= 4; k++) begin
      setall(k, 1);
      drive(1'b1, 1'b0);
      tick();
      if (k > 1) begin
        chk("burst_valid", longint'(bus.valid), 1);
        chk("burst_y1", longint'($signed(bus.Y1)), 9*(k-1));
      end
    end
    drive(1'b0, 1'b0);
    tick();
    chk("burst_last_y1", longint'($signed(bus.Y1)), 36);
    chk("burst_cnt", longint'(bus.res_cnt), 4);

    setall(5, 5);
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(bus.valid), 0);
    chk("midrst_y1", longint'($signed(bus.Y1)), 0);
    chk("midrst_cnt", longint'(bus.res_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("postrst_valid", longint'(bus.valid), 0);
    chk("postrst_y1", longint'($signed(bus.Y1)), 0);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 9; i++) begin
        pa[i] = rnd_op();
        wa[i] = rnd_op();
      end
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0));
      if (n == 1500) rst_n = 1'b0;
      if (n == 1502) rst_n = 1'b1;
      tick();
    end

    drive(1'b0, 1'b0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
